// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   rx_state_t     receiver FSM state encoding
//   calc_os_div()  clocks per oversample tick, rounded to nearest
//   maj3()         2-of-3 majority vote
package uart_pkg;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK} rx_state_t;

  // round(clk_freq / (baud * os)) in integer arithmetic
  function automatic int calc_os_div(input int clk_freq, input int baud, input int os);
    int den;
    den = baud * os;
    return (clk_freq + den / 2) / den;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, shared by rx and tx.
//   clk      system clock
//   rst      async active-low reset
//   restart  zero the divider so the next tick lands DIV clocks later
//   tick     one-cycle pulse every DIV clocks
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = calc_os_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver, 16x oversampled, LSB first.
//   clk          system clock
//   rst          async active-low reset
//   rx           serial line (async, idles high)
//   rx_data_out  received byte, stable while rx_valid
//   rx_valid     byte available, held until rx_ready
//   rx_ready     consumer accept
//   rx_busy      frame in progress (START/DATA/STOP)
//   frame_err    1-clk pulse, stop bit sampled low
//   overrun_err  1-clk pulse, byte dropped because rx_valid was still held
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 19_200,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_WIDTH - 1);

  // rx_s1/rx_s2 synchronize; rx_s3 is the previous synchronized value for edge detect
  logic rx_s1, rx_s2, rx_s3;
  logic fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign fall = rx_s3 & ~rx_s2;

  rx_state_t             state;
  logic [SW-1:0]         s;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  v0, v1;
  logic                  maj;
  logic                  deliver;
  logic                  tick;
  logic                  restart;

  // Divider phase is pinned to the detected start edge
  assign restart = (state == RX_IDLE) && fall;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // Third vote is the live sample taken at S_HI
  assign maj = maj3(v0, v1, rx_s2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RX_IDLE;
      s         <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      deliver   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      deliver   <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state   <= RX_START;
            s       <= '0;
            rx_busy <= 1'b1;
          end
        end
        // Line must return high before another start edge is accepted
        RX_BRK: begin
          if (rx_s2) state <= RX_IDLE;
        end
        default: begin
          if (tick) begin
            s <= (s == S_END) ? '0 : s + 1'b1;
            if (s == S_LO)  v0 <= rx_s2;
            if (s == S_MID) v1 <= rx_s2;
            if (s == S_HI) begin
              case (state)
                RX_START: begin
                  // High majority in the start bit: a glitch, drop silently
                  if (maj) begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                  end
                end
                RX_DATA: shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                RX_STOP: begin
                  // Leave mid stop bit so a back-to-back start edge is not missed
                  rx_busy <= 1'b0;
                  if (maj) begin
                    deliver <= 1'b1;
                    state   <= RX_IDLE;
                  end else begin
                    frame_err <= 1'b1;
                    state     <= RX_BRK;
                  end
                end
                default: ;
              endcase
            end
            if (s == S_END) begin
              case (state)
                RX_START: begin
                  state   <= RX_DATA;
                  bit_idx <= '0;
                end
                RX_DATA: begin
                  if (bit_idx == B_END) state <= RX_STOP;
                  else                  bit_idx <= bit_idx + 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Output holding register. A delivery coinciding with a handshake reloads
  // in place, so rx_valid stays high and no overrun is flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_out <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data_out <= shreg;
          rx_valid    <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
